// File: rtl/branch_resolve_unit_if.sv
// Interface bundling the pipeline-side signals of the branch resolve unit:
// ID capture inputs, EX operands, predictor update, redirect and statistics.
interface branch_resolve_unit_if #(
  parameter int CNT_W = 32
);
  // Pipeline to unit
  logic             stall;
  logic             id_valid;
  logic [31:0]      id_pc;
  logic             id_is_branch;
  logic             id_is_jal;
  logic             id_is_jalr;
  logic [2:0]       id_funct3;
  logic [31:0]      id_imm;
  logic             id_pred_taken;
  logic [31:0]      ex_rs1;
  logic [31:0]      ex_rs2;

  // Unit to pipeline / predictor
  logic             update_en;
  logic [31:0]      pc_ex;
  logic             actual_taken;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             flush;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport master (
    output stall, id_valid, id_pc, id_is_branch, id_is_jal, id_is_jalr,
           id_funct3, id_imm, id_pred_taken, ex_rs1, ex_rs2,
    input  update_en, pc_ex, actual_taken, redirect_valid, redirect_pc,
           flush, branch_cnt, mispred_cnt
  );

  modport slave (
    input  stall, id_valid, id_pc, id_is_branch, id_is_jal, id_is_jalr,
           id_funct3, id_imm, id_pred_taken, ex_rs1, ex_rs2,
    output update_en, pc_ex, actual_taken, redirect_valid, redirect_pc,
           flush, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: ID/EX register with stored prediction, outcome
// check, predictor update, mispredict redirect/flush, squash FSM and counters.
module branch_resolve_unit #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_resolve_unit_if.slave bus
);

  localparam int REM_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_SQUASH = 1'b1
  } state_e;

  typedef struct packed {
    logic        valid;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] pred_npc;
  } ex_reg_t;

  ex_reg_t          ex_q, ex_d;
  state_e           state_q, state_d;
  logic [REM_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [31:0] id_pred_npc;
  logic        cond_taken;
  logic        act_taken;
  logic [31:0] act_npc;
  logic [31:0] jalr_sum;
  logic        fire;
  logic        update_en;
  logic        redirect;

  // Predicted next PC, fixed at capture so EX only compares against it.
  always_comb begin
    id_pred_npc = bus.id_pc + 32'd4;
    if (bus.id_is_branch) begin
      if (bus.id_pred_taken) id_pred_npc = bus.id_pc + bus.id_imm;
    end else if (bus.id_is_jal) begin
      id_pred_npc = bus.id_pc + bus.id_imm;
    end
  end

  always_comb begin
    cond_taken = 1'b0;
    case (ex_q.funct3)
      3'b000:  cond_taken = (bus.ex_rs1 == bus.ex_rs2);
      3'b001:  cond_taken = (bus.ex_rs1 != bus.ex_rs2);
      3'b100:  cond_taken = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
      3'b101:  cond_taken = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
      3'b110:  cond_taken = (bus.ex_rs1 <  bus.ex_rs2);
      3'b111:  cond_taken = (bus.ex_rs1 >= bus.ex_rs2);
      default: cond_taken = 1'b0;
    endcase
  end

  always_comb begin
    act_taken = ex_q.is_branch && cond_taken;
    jalr_sum  = bus.ex_rs1 + ex_q.imm;
    act_npc   = ex_q.pc + 32'd4;
    if (ex_q.is_branch) begin
      if (act_taken) act_npc = ex_q.pc + ex_q.imm;
    end else if (ex_q.is_jal) begin
      act_npc = ex_q.pc + ex_q.imm;
    end else if (ex_q.is_jalr) begin
      act_npc = jalr_sum & 32'hFFFF_FFFE;
    end

    // A stalled instruction waits and fires once on release.
    fire      = ex_q.valid && !bus.stall && (state_q == ST_NORMAL);
    update_en = fire && ex_q.is_branch;
    redirect  = fire && (act_npc != ex_q.pred_npc);
  end

  // Capture priority: squash bubble beats stall, stall beats a new load.
  always_comb begin
    ex_d = ex_q;
    if (redirect || (state_q == ST_SQUASH)) begin
      ex_d = '0;
    end else if (!bus.stall) begin
      ex_d = '0;
      if (bus.id_valid) begin
        ex_d.valid     = 1'b1;
        ex_d.is_branch = bus.id_is_branch;
        ex_d.is_jal    = bus.id_is_jal;
        ex_d.is_jalr   = bus.id_is_jalr;
        ex_d.funct3    = bus.id_funct3;
        ex_d.pc        = bus.id_pc;
        ex_d.imm       = bus.id_imm;
        ex_d.pred_npc  = id_pred_npc;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      ST_NORMAL: begin
        if (redirect && (FLUSH_CYCLES > 1)) begin
          state_d     = ST_SQUASH;
          remaining_d = REM_W'(FLUSH_CYCLES - 1);
        end
      end
      ST_SQUASH: begin
        if (!bus.stall) begin
          if (remaining_q <= REM_W'(1)) begin
            state_d     = ST_NORMAL;
            remaining_d = '0;
          end else begin
            remaining_d = remaining_q - REM_W'(1);
          end
        end
      end
      default: begin
        state_d     = ST_NORMAL;
        remaining_d = '0;
      end
    endcase
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (update_en && (branch_cnt_q != '1))  branch_cnt_d  = branch_cnt_q + CNT_W'(1);
    if (redirect  && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
  end

  // NOTE: every flop, including the EX payload, is reset so no X can reach
  // the compare/redirect logic; state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q          <= '0;
      state_q       <= ST_NORMAL;
      remaining_q   <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      ex_q          <= ex_d;
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.update_en      = update_en;
  assign bus.pc_ex          = fire ? ex_q.pc : 32'd0;
  assign bus.actual_taken   = fire && act_taken;
  assign bus.redirect_valid = redirect;
  assign bus.redirect_pc    = fire ? act_npc : 32'd0;
  assign bus.flush          = redirect || (state_q == ST_SQUASH);
  assign bus.branch_cnt     = branch_cnt_q;
  assign bus.mispred_cnt    = mispred_cnt_q;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Sits in the EX stage and is the update-side counterpart of the 2-bit direction predictor.
- Holds an ID/EX register for control-flow instructions together with their ID-stage prediction. It resolves the real outcome, drives the predictor update port (update_en / pc_ex / actual_taken) and raises redirect and flush on a mispredict.
- A small squash FSM and saturating statistics counters complete the block.

Parameters:
- FLUSH_CYCLES, 1: total clock edges on which the EX register loads a bubble per redirect (≥1).
- CNT_W, 32: width of the statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  pipeline hold; EX register keeps its contents
- id_valid  in  1  valid instruction in ID
- id_pc  in  32  ID instruction PC
- id_is_branch  in  1  conditional branch (BEQ/BNE/BLT/BGE/BLTU/BGEU)
- id_is_jal  in  1  JAL
- id_is_jalr  in  1  JALR
- id_funct3  in  3  branch funct3
- id_imm  in  32  sign-extended immediate
- id_pred_taken  in  1  predictor direction for id_pc
- ex_rs1  in  32  forwarded rs1 operand in EX
- ex_rs2  in  32  forwarded rs2 operand in EX
- update_en  out  1  predictor update strobe
- pc_ex  out  32  PC of the resolving branch
- actual_taken  out  1  resolved direction
- redirect_valid  out  1  mispredict; fetch must restart
- redirect_pc  out  32  correct next PC
- flush  out  1  squash younger IF/ID instructions
- branch_cnt  out  CNT_W  resolved conditional branches
- mispred_cnt  out  CNT_W  redirects issued

Behaviour:
- Reset (asynchronous):
  - EX register becomes an invalid bubble; FSM goes to NORMAL; both counters clear to 0.
  - All outputs read 0.
- EX register capture, evaluated at each rising edge in this priority order:
  1. redirect_valid or FSM in SQUASH: load bubble. This overrides stall.
  2. stall: hold contents.
  3. Otherwise: load id_valid/id_* qualified by id_valid.
- Latency: an instruction captured from ID at edge N is resolved combinationally in the cycle after edge N.
- Predicted next PC, computed at capture and stored:
  - Conditional branch: id_pred_taken ? id_pc+id_imm : id_pc+4.
  - JAL: id_pc+id_imm (ID redirects it).
  - JALR: id_pc+4 (never predicted).
- Actual outcome in EX:
  - funct3 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge. Other funct3 values resolve as not taken.
  - Actual next PC:
    - Taken branch or JAL: pc+imm.
    - JALR: (ex_rs1+imm) with bit0 cleared.
    - Otherwise: pc+4.
  - All adds are 32-bit modulo; wrap-around is ignored.
- Fire condition = EX valid && !stall && FSM==NORMAL.
  - update_en = fire && is_branch. pc_ex = EX pc. actual_taken = condition result. JAL/JALR never update the predictor.
  - redirect_valid = fire && (actual next PC != predicted next PC). redirect_pc = actual next PC.
  - When an instruction is not firing, redirect_pc and pc_ex read 0.
- Stall with a mispredicting instruction in EX: no redirect or update. It fires once in the first cycle stall deasserts, so each instruction produces exactly one update and at most one redirect.
- Squash FSM:
  - NORMAL → SQUASH on redirect_valid when FLUSH_CYCLES>1, with remaining = FLUSH_CYCLES-1.
  - In SQUASH, remaining decrements on each edge where !stall. Exit to NORMAL after the edge where it reaches 0.
  - id_* inputs are ignored throughout SQUASH.
  - flush = redirect_valid || (FSM==SQUASH).
- Counters:
  - branch_cnt increments on update_en; mispred_cnt increments on redirect_valid.
  - Both saturate at all-ones and never wrap.
- Reset asserted mid-squash or mid-stall: immediate return to the reset state. No update or redirect fires in the reset cycle.

Test Plan:
- Mispredicted-not-taken BEQ:
  - Stimulus: id_pc=0x100, BEQ, imm=0x20, pred_taken=0, rs1=rs2=5.
  - Next cycle: update_en=1, actual_taken=1, pc_ex=0x100, redirect_valid=1, redirect_pc=0x120, flush=1. Following cycle EX is a bubble.
- Correct prediction:
  - Stimulus: BNE at 0x200, imm=0x40, pred_taken=1, rs1=1, rs2=2.
  - Response: update_en=1, actual_taken=1, redirect_valid=0, branch_cnt +1, mispred_cnt unchanged.
- Signed vs unsigned compare, with rs1=0xFFFFFFFF, rs2=1, pred_taken=0:
  - BLT → actual_taken=1, redirect.
  - BLTU → actual_taken=0, no redirect.
- JALR:
  - Stimulus: pc=0x300, rs1=0x1003, imm=4.
  - Response: redirect_pc=0x1006, update_en=0, mispred_cnt +1.
- Stall hold:
  - Stimulus: mispredicting branch in EX with stall=1 for 3 cycles.
  - Response: no redirect/update while stalled; exactly one redirect on the release cycle.
- FLUSH_CYCLES=3 with CNT_W=2:
  - Response: flush high for 3 cycles and id inputs ignored during that time. Four mispredicts leave mispred_cnt=3 (saturated).
  - Asserting rst_n low mid-squash clears the FSM and counters to 0.
